// File: rtl/ddr_weight_writer_pkg.sv
// Shared encodings for the DDR weight writer: FSM states, AXI constants,
// and the helper that derives bytes per data beat.
package ddr_weight_writer_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_RESP = 3'd3,
      S_DONE = 3'd4
   } wr_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [3:0] AXI_CACHE_BUF  = 4'b0010;

   // Bytes per beat at the default 512-bit data width.
   localparam int BEAT_BYTES = 64;

   function automatic int beat_bytes(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/ddr_weight_writer_fifo.sv
// First-word-fall-through staging FIFO with an occupancy count; the head
// word is presented on dout_o whenever the FIFO is not empty.
module weight_stage_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 64,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [CW-1:0]    count_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    cnt_q;
   logic             push_ok, pop_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q];
   assign count_o = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/ddr_weight_writer.sv
// Streams a job of weight beats into DDR as AXI4 INCR write bursts, staging
// input beats so a burst address is only issued once its data is on hand.
module ddr_weight_writer
   import ddr_weight_writer_pkg::*;
#(
   parameter int C_M_AXI_ID_WIDTH   = 4,
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 512,
   parameter int DMA_ADDR_WIDTH     = 27,
   parameter int BURST_LEN          = 16,
   parameter int FIFO_DEPTH         = 64
) (
   input  logic                            clk,
   input  logic                            m_axi_aresetn,
   input  logic                            start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   ddr_base_addr,
   input  logic [DMA_ADDR_WIDTH-1:0]       ddr_write_length,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   ddr_din,
   input  logic                            ddr_din_en,
   output logic                            ddr_din_rdy,
   input  logic                            ddr_din_eop,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]                      m_axi_awlen,
   output logic [2:0]                      m_axi_awsize,
   output logic [1:0]                      m_axi_awburst,
   output logic [3:0]                      m_axi_awcache,
   output logic                            m_axi_awvalid,
   output logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_awid,
   output logic                            m_axi_awlock,
   output logic [2:0]                      m_axi_awprot,
   output logic [3:0]                      m_axi_awqos,
   input  logic                            m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                            m_axi_wlast,
   output logic                            m_axi_wvalid,
   input  logic                            m_axi_wready,
   input  logic [1:0]                      m_axi_bresp,
   input  logic                            m_axi_bvalid,
   input  logic [C_M_AXI_ID_WIDTH-1:0]     m_axi_bid,
   output logic                            m_axi_bready,
   output logic                            busy,
   output logic                            done,
   output logic                            err
);

   localparam int AW    = C_M_AXI_ADDR_WIDTH;
   localparam int LW    = DMA_ADDR_WIDTH;
   localparam int BYTES = beat_bytes(C_M_AXI_DATA_WIDTH);
   localparam int ALIGN = $clog2(BURST_LEN * BYTES);
   localparam int BW    = $clog2(BURST_LEN + 1);
   localparam int CW    = $clog2(FIFO_DEPTH + 1);

   // Reset asserts asynchronously but releases on a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge m_axi_aresetn) begin
      if (!m_axi_aresetn) rst_sync_q <= 2'b00;
      else                rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   wr_state_e       state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [LW-1:0]   len_q, len_d;
   logic [LW-1:0]   rem_q, rem_d;
   logic [LW-1:0]   acc_q, acc_d;
   logic [BW-1:0]   burst_q, burst_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic            err_q, err_d;

   logic [BW-1:0]   b_cur;
   logic [CW-1:0]   fifo_cnt;
   logic            fifo_full, fifo_empty;
   logic            push, pop;
   logic            aw_fire, w_fire;
   logic            unused_bid;

   assign unused_bid = ^{m_axi_bid, fifo_empty};

   assign b_cur = (rem_q >= LW'(BURST_LEN)) ? BW'(BURST_LEN) : rem_q[BW-1:0];

   assign busy        = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_RESP);
   assign done        = (state_q == S_DONE);
   assign err         = err_q;
   assign ddr_din_rdy = busy && !fifo_full && (acc_q < len_q);
   assign push        = ddr_din_en && ddr_din_rdy;

   // Address goes out only once the whole burst is staged, so W never starves.
   assign m_axi_awvalid = (state_q == S_ADDR) && (fifo_cnt >= CW'(b_cur));
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = (state_q == S_ADDR) ? (8'(b_cur) - 8'd1) : 8'd0;
   assign m_axi_awsize  = 3'($clog2(BYTES));
   assign m_axi_awburst = AXI_BURST_INCR;
   assign m_axi_awcache = AXI_CACHE_BUF;
   assign m_axi_awid    = '0;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awprot  = 3'd0;
   assign m_axi_awqos   = 4'd0;
   assign aw_fire       = m_axi_awvalid && m_axi_awready;

   assign m_axi_wvalid  = (state_q == S_DATA);
   assign m_axi_wlast   = (state_q == S_DATA) && ((beat_q + BW'(1)) == burst_q);
   assign m_axi_wstrb   = '1;
   assign w_fire        = m_axi_wvalid && m_axi_wready;
   assign pop           = w_fire;

   assign m_axi_bready  = 1'b1;

   weight_stage_fifo #(
      .WIDTH (C_M_AXI_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   (ddr_din),
      .pop_i   (pop),
      .dout_o  (m_axi_wdata),
      .count_o (fifo_cnt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      len_d   = len_q;
      rem_d   = rem_q;
      acc_d   = acc_q;
      burst_d = burst_q;
      beat_d  = beat_q;
      err_d   = err_q;

      // eop must coincide exactly with the final beat of the job.
      if (push) begin
         acc_d = acc_q + LW'(1);
         if (ddr_din_eop != ((acc_q + LW'(1)) == len_q)) err_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = {ddr_base_addr[AW-1:ALIGN], ALIGN'(0)};
               len_d   = ddr_write_length;
               rem_d   = ddr_write_length;
               acc_d   = '0;
               err_d   = 1'b0;
               state_d = (ddr_write_length == '0) ? S_DONE : S_ADDR;
            end
         end
         S_ADDR: begin
            if (aw_fire) begin
               burst_d = b_cur;
               beat_d  = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (w_fire) begin
               beat_d = beat_q + BW'(1);
               if (m_axi_wlast) state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (m_axi_bvalid) begin
               if (m_axi_bresp != AXI_RESP_OKAY) err_d = 1'b1;
               addr_d  = addr_q + (AW'(burst_q) << $clog2(BYTES));
               rem_d   = rem_q - LW'(burst_q);
               state_d = (rem_q == LW'(burst_q)) ? S_DONE : S_ADDR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         rem_q   <= '0;
         acc_q   <= '0;
         burst_q <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         acc_q   <= acc_d;
         burst_q <= burst_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_ddr_weight_writer.sv
// Job-level bench: table of jobs plus random jobs, each checked against an
// arithmetic model of burst addresses, beat order and error outcome.
module tb_ddr_weight_writer;

   localparam int ID = 4;
   localparam int AW = 32;
   localparam int DW = 512;
   localparam int LW = 27;

   logic          clk = 1'b0;
   logic          m_axi_aresetn;
   logic          start;
   logic [AW-1:0] ddr_base_addr;
   logic [LW-1:0] ddr_write_length;
   logic [DW-1:0] ddr_din;
   logic          ddr_din_en, ddr_din_rdy, ddr_din_eop;
   logic [AW-1:0] m_axi_awaddr;
   logic [7:0]    m_axi_awlen;
   logic [2:0]    m_axi_awsize;
   logic [1:0]    m_axi_awburst;
   logic [3:0]    m_axi_awcache;
   logic          m_axi_awvalid, m_axi_awready, m_axi_awlock;
   logic [ID-1:0] m_axi_awid, m_axi_bid;
   logic [2:0]    m_axi_awprot;
   logic [3:0]    m_axi_awqos;
   logic [DW-1:0] m_axi_wdata;
   logic [DW/8-1:0] m_axi_wstrb;
   logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic [1:0]    m_axi_bresp;
   logic          m_axi_bvalid, m_axi_bready;
   logic          busy, done, err;

   always #5 clk = ~clk;

   ddr_weight_writer dut (
      .clk(clk), .m_axi_aresetn(m_axi_aresetn), .start(start),
      .ddr_base_addr(ddr_base_addr), .ddr_write_length(ddr_write_length),
      .ddr_din(ddr_din), .ddr_din_en(ddr_din_en), .ddr_din_rdy(ddr_din_rdy),
      .ddr_din_eop(ddr_din_eop),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awid(m_axi_awid), .m_axi_awlock(m_axi_awlock),
      .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bid(m_axi_bid),
      .m_axi_bready(m_axi_bready), .busy(busy), .done(done), .err(err)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      int          len;
      logic [31:0] base;
      int          eop_pos;
      int          err_burst;
      int          in_mode;
      int          aw_mode;
      int          w_mode;
      bit          exp_err;
      int          exp_bursts;
      bit          exp_full;
   } vec_t;

   function automatic logic [DW-1:0] rand512();
      logic [DW-1:0] d;
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic drive_idle();
      start = 1'b0; ddr_din_en = 1'b0; ddr_din_eop = 1'b0; ddr_din = '0;
      m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; m_axi_bid = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_awvalid"}, m_axi_awvalid, 0);
      chk({tag, "_wvalid"},  m_axi_wvalid, 0);
      chk({tag, "_wlast"},   m_axi_wlast, 0);
      chk({tag, "_awaddr"},  m_axi_awaddr, 0);
      chk({tag, "_awlen"},   m_axi_awlen, 0);
      chk({tag, "_busy"},    busy, 0);
      chk({tag, "_done"},    done, 0);
      chk({tag, "_err"},     err, 0);
      chk({tag, "_rdy"},     ddr_din_rdy, 0);
   endtask

   // Plays source, AXI slave and monitor for one job. Inputs change just
   // after the falling edge; everything is sampled 1ns later, well before
   // the rising edge at which the sampled handshakes take effect.
   task automatic run_job(input vec_t v, input bit abort);
      logic [DW-1:0] src[$];
      int acc = 0, widx = 0, awidx = 0, bidx = 0, bpend = 0, wbdone = 0;
      int done_cnt = 0, done_cyc = -1, max_occ = 0, stall = 0, occ, nb, exp_b;
      bit fin = 0, p_aws = 0, p_ws = 0, exp_last;
      logic [31:0] aligned, exp_addr, p_awaddr;
      logic [7:0]  p_awlen;
      logic [DW-1:0] p_wdata;
      logic p_wlast;

      nb = (v.len + 15) / 16;
      aligned = {v.base[31:10], 10'd0};
      for (int i = 0; i < v.len; i++) src.push_back(rand512());

      for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
         @(negedge clk);
         start = (cyc == 0) || (cyc == 6 && busy);
         ddr_base_addr    = (cyc == 0) ? v.base : 32'h0BAD_0000;
         ddr_write_length = (cyc == 0) ? LW'(v.len) : LW'(5);
         case (v.in_mode)
            1:       ddr_din_en = ($urandom % 4) != 0;
            2:       ddr_din_en = !(acc >= 10 && stall < 30);
            default: ddr_din_en = 1'b1;
         endcase
         if (v.in_mode == 2 && acc >= 10) stall++;
         if (acc >= v.len) ddr_din_en = 1'b0;
         ddr_din     = (acc < v.len) ? src[acc] : '0;
         ddr_din_eop = (acc + 1 == v.eop_pos);
         case (v.aw_mode)
            1:       m_axi_awready = $urandom % 2;
            2:       m_axi_awready = (cyc >= 150);
            default: m_axi_awready = 1'b1;
         endcase
         case (v.w_mode)
            1:       m_axi_wready = (cyc % 2 == 0);
            2:       m_axi_wready = $urandom % 2;
            default: m_axi_wready = 1'b1;
         endcase
         m_axi_bvalid = (bpend > 0);
         m_axi_bresp  = (bidx == v.err_burst) ? 2'b10 : 2'b00;
         #1;
         if (abort && awidx >= 2 && widx >= 19) return;

         occ = acc - widx;
         if (occ > max_occ) max_occ = occ;

         if (m_axi_awvalid) begin
            if (awidx < nb) begin
               exp_b    = (v.len - 16 * awidx < 16) ? v.len - 16 * awidx : 16;
               exp_addr = aligned + 32'(awidx) * 32'd1024;
               chk("awaddr", m_axi_awaddr, exp_addr);
               chk("awlen", m_axi_awlen, exp_b - 1);
               chk("aw_gate", occ >= exp_b, 1);
            end else chk("aw_extra", m_axi_awvalid, 0);
         end
         if (m_axi_wvalid) begin
            if (widx < v.len) begin
               exp_last = ((widx + 1) % 16 == 0) || (widx + 1 == v.len);
               chk("wdata", m_axi_wdata, src[widx]);
               chk("wlast", m_axi_wlast, exp_last);
               chk("w_after_aw", awidx > wbdone, 1);
            end else chk("w_extra", m_axi_wvalid, 0);
         end
         if (occ >= 64 || acc >= v.len) chk("rdy_block", ddr_din_rdy, 0);
         if (p_aws) begin
            chk("aw_hold", m_axi_awvalid, 1);
            chk("aw_hold_addr", m_axi_awaddr, p_awaddr);
            chk("aw_hold_len", m_axi_awlen, p_awlen);
         end
         if (p_ws) begin
            chk("w_hold", m_axi_wvalid, 1);
            chk("w_hold_data", m_axi_wdata, p_wdata);
            chk("w_hold_last", m_axi_wlast, p_wlast);
         end

         if (ddr_din_en && ddr_din_rdy) acc++;
         if (m_axi_awvalid && m_axi_awready) awidx++;
         if (m_axi_wvalid && m_axi_wready) begin
            if (m_axi_wlast) begin wbdone++; bpend++; end
            widx++;
         end
         if (m_axi_bvalid && m_axi_bready) begin bidx++; bpend--; end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         p_aws = m_axi_awvalid && !m_axi_awready;
         p_ws  = m_axi_wvalid && !m_axi_wready;
         p_awaddr = m_axi_awaddr; p_awlen = m_axi_awlen;
         p_wdata  = m_axi_wdata;  p_wlast = m_axi_wlast;
         if (done_cyc >= 0 && cyc >= done_cyc + 4) fin = 1;
      end

      chk("job_finished", done_cyc >= 0, 1);
      chk("done_count", done_cnt, 1);
      chk("bursts", awidx, v.exp_bursts);
      chk("beats", widx, v.len);
      chk("bresps", bidx, v.exp_bursts);
      chk("err", err, v.exp_err);
      chk("busy_idle", busy, 0);
      chk("fifo_bound", max_occ <= 64, 1);
      if (v.exp_full) chk("fifo_full", max_occ, 64);
      drive_idle();
   endtask

   vec_t vecs[8];

   initial begin
      vec_t rv;
      logic [DW/8-1:0] ones = '1;

      vecs[0] = '{40,  32'h1234_5678, 40,  -1, 0, 0, 0, 0, 3, 0};
      vecs[1] = '{16,  32'h0000_4000, 16,  -1, 0, 0, 1, 0, 1, 0};
      vecs[2] = '{100, 32'h2000_0000, 100, -1, 2, 2, 0, 0, 7, 1};
      vecs[3] = '{40,  32'h0001_0000, 40,   1, 0, 1, 2, 1, 3, 0};
      vecs[4] = '{8,   32'h0000_0800, 5,   -1, 0, 0, 0, 1, 1, 0};
      vecs[5] = '{0,   32'h0000_1000, 0,   -1, 0, 0, 0, 0, 0, 0};
      vecs[6] = '{33,  32'hFFFF_FC00, 33,  -1, 1, 1, 2, 0, 3, 0};
      vecs[7] = '{17,  32'h0000_03FF, 17,  -1, 1, 0, 1, 0, 2, 0};

      drive_idle();
      ddr_base_addr = '0; ddr_write_length = '0;
      m_axi_aresetn = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("reset");
      m_axi_aresetn = 1'b1;
      repeat (3) @(negedge clk);

      chk("awsize", m_axi_awsize, 3'b110);
      chk("awburst", m_axi_awburst, 2'b01);
      chk("awcache", m_axi_awcache, 4'b0010);
      chk("aw_id_lock_prot_qos", {m_axi_awid, m_axi_awlock, m_axi_awprot, m_axi_awqos}, 0);
      chk("wstrb", m_axi_wstrb, ones);
      chk("bready", m_axi_bready, 1);

      for (int i = 0; i < 8; i++) run_job(vecs[i], 1'b0);

      for (int i = 0; i < 5; i++) begin
         rv.len        = $urandom_range(1, 70);
         rv.base       = $urandom;
         rv.exp_bursts = (rv.len + 15) / 16;
         rv.eop_pos    = ($urandom % 4 == 0) ? $urandom_range(1, rv.len) : rv.len;
         rv.err_burst  = ($urandom % 3 == 0) ? $urandom_range(0, rv.exp_bursts - 1) : -1;
         rv.in_mode    = $urandom_range(0, 1);
         rv.aw_mode    = $urandom_range(0, 1);
         rv.w_mode     = $urandom_range(0, 2);
         rv.exp_err    = (rv.eop_pos != rv.len) || (rv.err_burst >= 0);
         rv.exp_full   = 1'b0;
         run_job(rv, 1'b0);
      end

      // Reset during the second burst's data phase, then a one-beat job.
      rv = '{40, 32'h8000_0000, 40, -1, 0, 0, 0, 0, 3, 0};
      run_job(rv, 1'b1);
      #1 m_axi_aresetn = 1'b0;
      #1 check_reset_outputs("midreset");
      drive_idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("rst_hold_awvalid", m_axi_awvalid, 0);
         chk("rst_hold_wvalid", m_axi_wvalid, 0);
      end
      m_axi_aresetn = 1'b1;
      repeat (3) @(negedge clk);
      rv = '{1, 32'h0000_2000, 1, -1, 0, 0, 0, 0, 1, 0};
      run_job(rv, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ddr_weight_writer.md
DDR_WEIGHT_WRITER -- requirements
Module: ddr_weight_writer

Interface
REQ-001 Parameters (name, default, meaning), one per line SHALL be:
- C_M_AXI_ID_WIDTH, 4, AXI ID width
- C_M_AXI_ADDR_WIDTH, 32, AXI address width
- C_M_AXI_DATA_WIDTH, 512, data beat width
- DMA_ADDR_WIDTH, 27, beat-count width
- BURST_LEN, 16, max beats per AXI burst
- FIFO_DEPTH, 64, staging FIFO depth in beats (>= 2*BURST_LEN)
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, sole clock
- m_axi_aresetn, in, 1, asynchronous active-low reset
- start, in, 1, one-cycle pulse that latches a job
- ddr_base_addr, in, C_M_AXI_ADDR_WIDTH, DDR byte address; low log2(BURST_LEN*DATA_WIDTH/8) bits ignored (treated as zero)
- ddr_write_length, in, DMA_ADDR_WIDTH, job size in beats
- ddr_din, in, C_M_AXI_DATA_WIDTH, weight beat
- ddr_din_en, in, 1, beat valid
- ddr_din_rdy, out, 1, beat ready
- ddr_din_eop, in, 1, last beat of job
- m_axi_aw{addr,len,size,burst,cache,valid,id,lock,prot,qos}, out, AXI4 widths, write address
- m_axi_awready, in, 1, write address ready
- m_axi_w{data,strb,last,valid}, out, AXI4 widths, write data
- m_axi_wready, in, 1, write data ready
- m_axi_b{resp,valid,id}, in, AXI4 widths, write response
- m_axi_bready, out, 1, write response ready
- busy, out, 1, job in progress
- done, out, 1, one-cycle job completion pulse
- err, out, 1, sticky error flag

Function
REQ-003 Input beat SHALL be accepted when ddr_din_en && ddr_din_rdy; ddr_din_rdy = busy && FIFO not full and accepted-count < length.
REQ-004 Constants SHALL be: awsize=log2(DATA_WIDTH/8) (3'b110), awburst=INCR, awcache=4'b0010, awid/lock/prot/qos=0, wstrb all ones, bready=1.
REQ-005 FSM states SHALL be IDLE, ADDR, DATA, RESP, DONE.
REQ-006 IDLE: start latches addr (aligned) and length, clears counters and err, goes ADDR; start while busy SHALL be ignored; start with length 0 SHALL go directly to DONE.
REQ-007 ADDR: burst size B=min(BURST_LEN, beats remaining); awvalid SHALL assert only when FIFO count >= B; awlen=B-1; on awready go DATA.
REQ-008 awvalid/wvalid SHALL never deassert before their handshake completes; AW and W SHALL be serialized (W beats only after AW accepted).
REQ-009 DATA: wdata SHALL be FIFO head; wlast SHALL assert on beat B of the burst; after last beat accepted go RESP.
REQ-010 RESP: on bvalid, bresp != OKAY SHALL set err; address SHALL advance by B*DATA_WIDTH/8; remaining -= B; go ADDR if remaining > 0, else DONE.
REQ-011 DONE: assert done for exactly one cycle, return to IDLE; busy=1 in ADDR, DATA, RESP.
REQ-012 ddr_din_eop on a beat other than beat number `length` (or missing eop on that beat) SHALL set err; data SHALL still be written unchanged.
REQ-013 Beat and address counters SHALL be unsigned, width DMA_ADDR_WIDTH and C_M_AXI_ADDR_WIDTH; address wrap at 2^ADDR_WIDTH SHALL be modulo, no error.
REQ-014 Simultaneous FIFO push and pop SHALL keep count unchanged; full FIFO SHALL only drop ddr_din_rdy, never beats.

Reset
REQ-015 Asynchronous assertion of m_axi_aresetn low SHALL immediately force: FSM IDLE, awvalid=0, wvalid=0, wlast=0, awaddr=0, awlen=0, busy=0, done=0, err=0, ddr_din_rdy=0, FIFO empty.
REQ-016 Reset mid-burst SHALL abandon the job with no further AXI activity; deassertion SHALL be synchronized before use.

Structure
REQ-017 A shared package SHALL hold FSM state encoding, AXI constant encodings (INCR, OKAY, cache) and the beat-bytes constant.
REQ-018 One sub-module, weight_stage_fifo (synchronous FWFT FIFO with count output, same async reset), SHALL implement staging.

Verification
REQ-019 Length 40, continuous input, awready/wready always 1 -> bursts awlen 15,15,7; addresses base, base+1024, base+2048; done once; err=0.
REQ-020 Length 16, wready toggling 1-0 -> wvalid held stable while low; wlast only on beat 16; data order preserved.
REQ-021 Length 100, input stalls with FIFO count 10 -> no awvalid until count >= 16; ddr_din_rdy low when FIFO holds 64.
REQ-022 bresp=SLVERR on second of three bursts -> err=1 sticky; all bursts completed; done pulses.
REQ-023 eop on beat 5 of length 8 -> err=1; 8 beats written.
REQ-024 Reset low during DATA of burst 2 -> all outputs at reset values same cycle; new start of length 1 afterwards -> single awlen=0 burst, done.
